// File: rtl/pipe_gen_if.sv
// Handshake bundle between the pipe generator and its environment:
// frame/control inputs and the registered pipe geometry outputs.
interface pipe_gen_if;
  logic       frame_tick;
  logic       start;
  logic       stop;
  logic [3:0] randbit;
  logic [9:0] pipe_x;
  logic [9:0] gap_top;
  logic [9:0] gap_bot;
  logic       score_pulse;
  logic       running;

  modport master (
    output frame_tick, start, stop, randbit,
    input  pipe_x, gap_top, gap_bot, score_pulse, running
  );

  modport slave (
    input  frame_tick, start, stop, randbit,
    output pipe_x, gap_top, gap_bot, score_pulse, running
  );
endinterface

// File: rtl/pipe_gen.sv
// Scrolling pipe generator: moves one pipe right-to-left per frame tick,
// relatches its gap from randbit on start/wrap and pulses when it passes the bird.
module pipe_gen #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W   = 60,
  parameter int GAP_BASE = 40,
  parameter int GAP_STEP = 16,
  parameter int GAP_H    = 120,
  parameter int BIRD_X   = 160,
  parameter int SPEED    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_gen_if.slave  bus
);

  localparam logic [9:0] RELOAD     = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] SPEED_V    = 10'(SPEED);
  localparam logic [9:0] BIRD_V     = 10'(BIRD_X);
  localparam logic [9:0] GAP_BASE_V = 10'(GAP_BASE);
  localparam logic [9:0] GAP_STEP_V = 10'(GAP_STEP);
  localparam logic [9:0] GAP_H_V    = 10'(GAP_H);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] pipe_x_q, pipe_x_d;
  logic [9:0] gap_top_q, gap_top_d;
  logic [9:0] gap_bot_q, gap_bot_d;
  logic       score_q, score_d;
  logic       running_q, running_d;
  logic [9:0] pipe_x_step;
  logic       gap_latch;

  function automatic logic [9:0] gap_top_f(input logic [3:0] rb);
    gap_top_f = GAP_BASE_V + ({6'd0, rb} * GAP_STEP_V);
  endfunction

  // Next-state logic; randbit only reaches the gap registers through gap_latch.
  always_comb begin
    state_d     = state_q;
    pipe_x_d    = pipe_x_q;
    score_d     = 1'b0;
    gap_latch   = 1'b0;
    pipe_x_step = pipe_x_q - SPEED_V;

    case (state_q)
      ST_IDLE: begin
        pipe_x_d = RELOAD;
        if (bus.start && !bus.stop) begin
          state_d   = ST_RUN;
          gap_latch = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_HALT;
        end else if (bus.frame_tick) begin
          if (pipe_x_q > SPEED_V) begin
            pipe_x_d = pipe_x_step;
            score_d  = (pipe_x_q >= BIRD_V) && (pipe_x_step < BIRD_V);
          end else begin
            pipe_x_d  = RELOAD;
            gap_latch = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (bus.start && !bus.stop) begin
          state_d   = ST_RUN;
          pipe_x_d  = RELOAD;
          gap_latch = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pipe_x_d = RELOAD;
      end
    endcase

    if (gap_latch) begin
      gap_top_d = gap_top_f(bus.randbit);
      gap_bot_d = gap_top_f(bus.randbit) + GAP_H_V;
    end else begin
      gap_top_d = gap_top_q;
      gap_bot_d = gap_bot_q;
    end

    running_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pipe_x_q  <= RELOAD;
      gap_top_q <= GAP_BASE_V;
      gap_bot_q <= GAP_BASE_V + GAP_H_V;
      score_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pipe_x_q  <= pipe_x_d;
      gap_top_q <= gap_top_d;
      gap_bot_q <= gap_bot_d;
      score_q   <= score_d;
      running_q <= running_d;
    end
  end

  assign bus.pipe_x      = pipe_x_q;
  assign bus.gap_top     = gap_top_q;
  assign bus.gap_bot     = gap_bot_q;
  assign bus.score_pulse = score_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Scoreboard bench for pipe_gen: a behavioural game model predicts every cycle's
// outputs, a monitor compares them after each clock edge, plus directed checkpoints.
module tb_pipe_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_gen_if bus ();

  pipe_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int top;
    int bot;
    bit sp;
    bit run;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model of the game: is the pipe scrolling, where is it, where is the gap.
  bit m_run = 1'b0;
  int m_x   = 700;
  int m_top = 40;
  int m_bot = 160;
  bit m_sp  = 1'b0;

  task automatic model_step(input bit r, input bit tick, input bit st, input bit sp, input int rb);
    if (!r) begin
      m_run = 1'b0; m_x = 700; m_top = 40; m_bot = 160; m_sp = 1'b0;
    end else begin
      m_sp = 1'b0;
      if (m_run) begin
        if (sp) begin
          m_run = 1'b0;
        end else if (tick) begin
          if (m_x > 2) begin
            m_sp = (m_x >= 160) && (m_x - 2 < 160);
            m_x  = m_x - 2;
          end else begin
            m_x = 700; m_top = 40 + rb * 16; m_bot = m_top + 120;
          end
        end
      end else if (st && !sp) begin
        m_run = 1'b1; m_x = 700; m_top = 40 + rb * 16; m_bot = m_top + 120;
      end
    end
  endtask

  task automatic check_vals(input string name, input int x, input int top, input int bot,
                            input bit sp, input bit run);
    n_checks++;
    if (int'(bus.pipe_x) != x || int'(bus.gap_top) != top || int'(bus.gap_bot) != bot ||
        bus.score_pulse !== sp || bus.running !== run) begin
      n_errors++;
      $display("FAIL %s @%0t: got x=%0d top=%0d bot=%0d sp=%b run=%b, want x=%0d top=%0d bot=%0d sp=%b run=%b",
               name, $time, bus.pipe_x, bus.gap_top, bus.gap_bot, bus.score_pulse, bus.running,
               x, top, bot, sp, run);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the model's prediction.
  task automatic cyc(input bit r, input bit tick, input bit st, input bit sp, input logic [3:0] rb);
    exp_t e;
    @(negedge clk);
    rst_n = r; bus.frame_tick = tick; bus.start = st; bus.stop = sp; bus.randbit = rb;
    model_step(r, tick, st, sp, int'(rb));
    e = '{m_x, m_top, m_bot, m_sp, m_run};
    sb_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic check_now(input string name, input int x, input int top, input int bot,
                           input bit sp, input bit run);
    @(posedge clk);
    #2;
    check_vals(name, x, top, bot, sp, run);
  endtask

  // Monitor: every edge for which a prediction exists, compare the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_vals("scoreboard", e.x, e.top, e.bot, e.sp, e.run);
      end
    end
  end

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.randbit = 4'd0;

    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    check_now("reset", 700, 40, 160, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
    check_now("start", 700, 104, 224, 1'b0, 1'b1);

    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
    end
    check_now("scroll100", 500, 104, 224, 1'b0, 1'b1);

    ticks(169);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    check_now("at_bird", 160, 104, 224, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    check_now("score", 158, 104, 224, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
    check_now("score_one_cycle", 158, 104, 224, 1'b0, 1'b1);

    ticks(78);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
    check_now("wrap", 700, 280, 400, 1'b0, 1'b1);

    ticks(269);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
    check_now("stop_tick", 162, 280, 400, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    check_now("halt_frozen", 162, 280, 400, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    check_now("restart", 700, 40, 160, 1'b0, 1'b1);

    ticks(270);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
    check_now("reset_pulse_due", 700, 40, 160, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    ticks(271);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
    check_now("reset_mid_pulse", 700, 40, 160, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 59) == 0),
          4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
